// File: rtl/embedded_system_nios2_oci_dct_capture_pkg.sv
// Shared state encodings and width helpers for the OCI DCT capture buffer.
package embedded_system_nios2_oci_dct_capture_pkg;

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DONE    = 2'd2
  } dct_state_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/embedded_system_nios2_oci_dct_capture_if.sv
// Output trace stream towards the host consumer: head word, tag and valid/ready.
interface embedded_system_nios2_oci_dct_capture_if #(
  parameter int WORD_W = 30,
  parameter int CNT_W  = 4
);
  logic [WORD_W-1:0] out_data;
  logic [CNT_W-1:0]  out_count;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_data, output out_count, output out_valid, input out_ready);
  modport slave  (input out_data, input out_count, input out_valid, output out_ready);
endinterface

// File: rtl/embedded_system_nios2_oci_dct_fifo.sv
// Show-ahead FIFO whose head word and valid are held in registers.
module embedded_system_nios2_oci_dct_fifo
  import embedded_system_nios2_oci_dct_capture_pkg::*;
#(
  parameter int DATA_W = 34,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-1:0]       dout,
  output logic                    dout_valid,
  output logic                    full,
  output logic                    empty,
  output logic [lvl_w(DEPTH)-1:0] level
);
  localparam int PTR_W = ptr_w(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0]  cnt_q, cnt_d, remain;
  logic [DATA_W-1:0] head_q, head_d;
  logic              vld_q, vld_d;
  logic              push_ok, pop_ok;

  assign full    = (cnt_q == LVL_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign remain  = cnt_q - LVL_W'(pop_ok);

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    vld_d  = vld_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      vld_d = 1'b0;
    end else begin
      if (push_ok) wr_d = wr_q + PTR_W'(1);
      if (pop_ok)  rd_d = rd_q + PTR_W'(1);
      cnt_d = remain + LVL_W'(push_ok);
      vld_d = (cnt_d != '0);
      // The head register is refilled from the incoming word only when the queue would otherwise be empty.
      if (cnt_d != '0) begin
        if (remain == '0) head_d = din;
        else              head_d = mem_q[rd_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      vld_q  <= vld_d;
    end
  end

  assign dout       = head_q;
  assign dout_valid = vld_q;
  assign level      = cnt_q;
endmodule

// File: rtl/embedded_system_nios2_oci_dct_capture.sv
// DCT trace capture buffer: push gating, overflow counter and end-of-test sequencing.
module embedded_system_nios2_oci_dct_capture
  import embedded_system_nios2_oci_dct_capture_pkg::*;
#(
  parameter int WORD_W = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int OVF_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WORD_W-1:0]       dct_buffer,
  input  logic [CNT_W-1:0]        dct_count,
  input  logic                    dct_valid,
  input  logic                    test_ending,
  input  logic                    test_has_ended,
  embedded_system_nios2_oci_dct_capture_if.master strm,
  output logic [lvl_w(DEPTH)-1:0] level,
  output logic [OVF_W-1:0]        overflow_cnt,
  output logic                    done
);
  dct_state_e         state_q, state_d;
  logic [OVF_W-1:0]   ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               fifo_push, fifo_pop, fifo_flush, ovf_inc;
  logic               fifo_full, fifo_empty, fifo_vld, pop_req;
  logic [WORD_W+CNT_W-1:0] fifo_dout;

  assign pop_req = fifo_vld && strm.out_ready;

  always_comb begin
    state_d    = state_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    ovf_inc    = 1'b0;
    case (state_q)
      ST_CAPTURE: begin
        fifo_pop = pop_req;
        if (dct_valid) begin
          if (!fifo_full || pop_req) fifo_push = 1'b1;
          else                       ovf_inc   = 1'b1;
        end
        if (test_ending) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        fifo_pop = pop_req;
        if (fifo_empty) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_DONE;
    endcase
    // An abort wins over everything else this cycle and throws the queue away.
    if (test_has_ended) begin
      state_d    = ST_DONE;
      fifo_flush = 1'b1;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      ovf_inc    = 1'b0;
    end
  end

  always_comb begin
    ovf_d  = ovf_q;
    if (ovf_inc && (ovf_q != {OVF_W{1'b1}})) ovf_d = ovf_q + OVF_W'(1);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CAPTURE;
      ovf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  embedded_system_nios2_oci_dct_fifo #(
    .DATA_W (WORD_W + CNT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .flush      (fifo_flush),
    .din        ({dct_count, dct_buffer}),
    .dout       (fifo_dout),
    .dout_valid (fifo_vld),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (level)
  );

  assign strm.out_data  = fifo_dout[WORD_W-1:0];
  assign strm.out_count = fifo_dout[WORD_W+CNT_W-1:WORD_W];
  assign strm.out_valid = fifo_vld;
  assign overflow_cnt   = ovf_q;
  assign done           = done_q;
endmodule

// File: tb/tb_embedded_system_nios2_oci_dct_capture.sv
// Directed bench for the DCT capture buffer; a second instance with a 2-bit overflow counter checks saturation.
module tb_embedded_system_nios2_oci_dct_capture;
  logic        clk, reset, dvalid, tend, tended, rdy;
  logic [29:0] dbuf;
  logic [3:0]  dcnt;
  logic [4:0]  lvl_a, lvl_b;
  logic [7:0]  ovf_a;
  logic [1:0]  ovf_b;
  logic        done_a, done_b;
  int          n_cmp, n_err;

  embedded_system_nios2_oci_dct_capture_if #(.WORD_W(30), .CNT_W(4)) if_a ();
  embedded_system_nios2_oci_dct_capture_if #(.WORD_W(30), .CNT_W(4)) if_b ();
  assign if_a.out_ready = rdy;
  assign if_b.out_ready = rdy;

  embedded_system_nios2_oci_dct_capture #(.WORD_W(30), .CNT_W(4), .DEPTH(16), .OVF_W(8)) dut_a (
    .clk(clk), .reset(reset), .dct_buffer(dbuf), .dct_count(dcnt), .dct_valid(dvalid),
    .test_ending(tend), .test_has_ended(tended), .strm(if_a),
    .level(lvl_a), .overflow_cnt(ovf_a), .done(done_a));

  embedded_system_nios2_oci_dct_capture #(.WORD_W(30), .CNT_W(4), .DEPTH(16), .OVF_W(2)) dut_b (
    .clk(clk), .reset(reset), .dct_buffer(dbuf), .dct_count(dcnt), .dct_valid(dvalid),
    .test_ending(tend), .test_has_ended(tended), .strm(if_b),
    .level(lvl_b), .overflow_cnt(ovf_b), .done(done_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [29:0] d, input logic [3:0] c);
    dvalid = 1'b1;
    dbuf   = d;
    dcnt   = c;
    step();
    dvalid = 1'b0;
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_valid"}, 64'(if_a.out_valid), 64'd0);
    check_eq({tag, "_data"},  64'(if_a.out_data),  64'd0);
    check_eq({tag, "_count"}, 64'(if_a.out_count), 64'd0);
    check_eq({tag, "_level"}, 64'(lvl_a),          64'd0);
    check_eq({tag, "_ovf"},   64'(ovf_a),          64'd0);
    check_eq({tag, "_done"},  64'(done_a),         64'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; dvalid = 1'b0; tend = 1'b0; tended = 1'b0; rdy = 1'b0;
    dbuf = '0; dcnt = '0;
    step(); step();
    check_reset_vals("rst");
    reset = 1'b0;

    // basic capture
    for (int i = 1; i <= 3; i++) begin
      push_word(30'(i), 4'(i));
      check_eq("cap_level", 64'(lvl_a), 64'(i));
      check_eq("cap_valid", 64'(if_a.out_valid), 64'd1);
    end
    step();
    check_eq("cap_head_data", 64'(if_a.out_data), 64'h1);
    check_eq("cap_head_cnt",  64'(if_a.out_count), 64'd1);
    check_eq("cap_hold_level", 64'(lvl_a), 64'd3);
    rdy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      check_eq("cap_rd_data", 64'(if_a.out_data), 64'(i));
      check_eq("cap_rd_cnt",  64'(if_a.out_count), 64'(i));
      step();
    end
    check_eq("cap_empty_level", 64'(lvl_a), 64'd0);
    check_eq("cap_empty_valid", 64'(if_a.out_valid), 64'd0);
    step();
    check_eq("cap_no_pop_empty", 64'(lvl_a), 64'd0);
    rdy = 1'b0;

    // overflow
    for (int i = 0; i < 20; i++) push_word(30'(i), 4'(i));
    check_eq("ovf_level", 64'(lvl_a), 64'd16);
    check_eq("ovf_cnt8",  64'(ovf_a), 64'd4);
    check_eq("ovf_cnt2",  64'(ovf_b), 64'd3);
    check_eq("ovf_head",  64'(if_a.out_data), 64'd0);
    for (int i = 0; i < 10; i++) push_word(30'(100 + i), 4'd0);
    check_eq("ovf_cnt8_more", 64'(ovf_a), 64'd14);
    check_eq("ovf_cnt2_sat",  64'(ovf_b), 64'd3);

    // full with simultaneous push and pop
    rdy = 1'b1;
    push_word(30'h100, 4'd5);
    rdy = 1'b0;
    check_eq("fpp_level", 64'(lvl_a), 64'd16);
    check_eq("fpp_ovf",   64'(ovf_a), 64'd14);
    check_eq("fpp_head",  64'(if_a.out_data), 64'd1);
    rdy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check_eq("fpp_rd_data", 64'(if_a.out_data), (i == 16) ? 64'h100 : 64'(i));
      check_eq("fpp_rd_cnt",  64'(if_a.out_count), (i == 16) ? 64'd5 : 64'(i));
      step();
    end
    rdy = 1'b0;
    check_eq("fpp_empty", 64'(lvl_a), 64'd0);

    // graceful end
    for (int i = 0; i < 5; i++) push_word(30'h200 + 30'(i), 4'(i));
    tend = 1'b1;
    push_word(30'h2AA, 4'hA);
    tend = 1'b0;
    check_eq("end_level", 64'(lvl_a), 64'd6);
    for (int i = 0; i < 3; i++) push_word(30'h2BB, 4'hB);
    check_eq("end_ignore_level", 64'(lvl_a), 64'd6);
    check_eq("end_ignore_ovf",   64'(ovf_a), 64'd14);
    check_eq("end_not_done",     64'(done_a), 64'd0);
    rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_eq("end_rd_data", 64'(if_a.out_data), (i == 5) ? 64'h2AA : 64'h200 + 64'(i));
      step();
    end
    check_eq("end_drained", 64'(lvl_a), 64'd0);
    check_eq("end_done_early", 64'(done_a), 64'd0);
    step();
    check_eq("end_done", 64'(done_a), 64'd1);
    rdy = 1'b0;
    push_word(30'h2CC, 4'hC);
    check_eq("done_inert_level", 64'(lvl_a), 64'd0);
    check_eq("done_ovf_kept",    64'(ovf_a), 64'd14);
    check_eq("done_sticky",      64'(done_a), 64'd1);

    // abort
    async_reset();
    check_eq("abr_rst_ovf",  64'(ovf_a), 64'd0);
    check_eq("abr_rst_done", 64'(done_a), 64'd0);
    release_reset();
    for (int i = 0; i < 7; i++) push_word(30'h300 + 30'(i), 4'(i));
    check_eq("abr_level_pre", 64'(lvl_a), 64'd7);
    tend = 1'b1; tended = 1'b1;
    push_word(30'h3FF, 4'hF);
    tend = 1'b0; tended = 1'b0;
    check_eq("abr_done",  64'(done_a), 64'd1);
    check_eq("abr_level", 64'(lvl_a), 64'd0);
    check_eq("abr_valid", 64'(if_a.out_valid), 64'd0);

    // reset mid-drain
    async_reset();
    release_reset();
    for (int i = 0; i < 20; i++) push_word(30'h400 + 30'(i), 4'(i));
    tend = 1'b1;
    step();
    tend = 1'b0;
    rdy = 1'b1;
    step();
    check_eq("rmd_level", 64'(lvl_a), 64'd15);
    check_eq("rmd_ovf",   64'(ovf_a), 64'd4);
    async_reset();
    check_reset_vals("rmd");
    rdy = 1'b0;
    release_reset();
    push_word(30'h3A1, 4'h1);
    push_word(30'h3A2, 4'h2);
    check_eq("post_level", 64'(lvl_a), 64'd2);
    check_eq("post_head",  64'(if_a.out_data), 64'h3A1);
    check_eq("post_cnt",   64'(if_a.out_count), 64'd1);
    check_eq("post_done",  64'(done_a), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/embedded_system_nios2_oci_dct_capture.md
# embedded_system_nios2_oci_dct_capture

Parametrised capture buffer for the Nios II OCI debug-trace (DCT) stream. It replaces the port-only OCI test-bench stub with a block that stores DCT words and their beat counts in a FIFO, drains them over a valid/ready stream, and counts overflow. It also sequences the end-of-test handshake (`test_ending`, `test_has_ended`) into a clean drain-then-done indication. It sits beside the OCI in the embedded_system debug path and feeds a host-side trace consumer.

## Interface
- `WORD_W`, 30, width of one DCT word
- `CNT_W`, 4, width of the DCT beat-count tag
- `DEPTH`, 16, FIFO entries; power of two, at least 2
- `OVF_W`, 8, width of the saturating overflow counter

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-high
- `dct_buffer` in WORD_W: trace word
- `dct_count` in CNT_W: beat count tagged to the word
- `dct_valid` in 1: capture strobe, one word per cycle
- `test_ending` in 1: level; request graceful stop
- `test_has_ended` in 1: level; abort, discard contents
- `out_data` out WORD_W: head-of-FIFO word
- `out_count` out CNT_W: head-of-FIFO count tag
- `out_valid` out 1: head entry valid
- `out_ready` in 1: consumer accepts head
- `level` out $clog2(DEPTH)+1: current occupancy
- `overflow_cnt` out OVF_W: words dropped while full, saturating
- `done` out 1: capture session finished (sticky)

## Operation
- States are CAPTURE, DRAIN and DONE. Reset enters CAPTURE.
- CAPTURE:
  - Push `{dct_count, dct_buffer}` when `dct_valid`, provided the FIFO is not full or a pop occurs in the same cycle.
  - Otherwise the word is dropped and `overflow_cnt` increments, saturating at 2^OVF_W−1.
- Pop occurs when `out_valid && out_ready`.
- CAPTURE→DRAIN on `test_ending`. `dct_valid` on that same edge is still captured. In DRAIN, `dct_valid` is ignored and not counted as overflow.
- DRAIN→DONE when the FIFO is empty, including a pop that empties it, evaluated on the following edge.
- `test_has_ended`:
  - From any state, goes to DONE on the next edge. The FIFO is flushed (level←0, `out_valid`←0) and the same-cycle push/pop is discarded.
  - Takes priority over `test_ending`.
- DONE: `done`=1 and the block is inert. Only `reset` leaves DONE.
- `overflow_cnt` is preserved through DRAIN/DONE and cleared only by reset.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_count`=0, `level`=0, `overflow_cnt`=0, `done`=0, state CAPTURE.
- All outputs are registered.
- Write-to-read latency is 1 cycle: a word pushed at edge N gives `out_valid`=1 after edge N, with no combinational fall-through.
- `out_data`/`out_count` hold stable while `out_valid && !out_ready`.
- Full with simultaneous push and pop: both occur and `level` is unchanged.
- Empty with `out_ready`=1: no pop.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- `done` rises 1 edge after the DRAIN-empty condition, or 1 edge after `test_has_ended` is sampled.
- Reset asserted mid-drain clears everything immediately, asynchronously.

## Structure
- A shared package/include holds the state encodings (CAPTURE=2'd0, DRAIN=2'd1, DONE=2'd2) and the `$clog2`-derived width localparams.
- One sub-module, `embedded_system_nios2_oci_dct_fifo`: a synchronous show-ahead FIFO, parametrised on data width WORD_W+CNT_W and DEPTH, with `push`, `pop`, `flush`, `full`, `empty` and `level`.
- The top level contains the FSM, overflow counter and push gating.

## Test plan
- **Basic capture:** After reset, push 3 words (0x1, 0x2, 0x3; counts 1, 2, 3) with `out_ready`=0. Expect `level`=3, `out_data`=0x1, `out_count`=1. Then set `out_ready`=1 and expect 0x1, 0x2, 0x3 in order, with `level` returning to 0.
- **Overflow:** With DEPTH=16 and `out_ready`=0, push 20 words. Expect `level`=16 and `overflow_cnt`=4, with the FIFO holding words 0–15. With OVF_W=2, push 10 extra words and expect `overflow_cnt`=3 (saturated).
- **Full push/pop:** With the FIFO full, present `dct_valid` and `out_ready` in the same cycle. Expect `level` to stay at 16, `overflow_cnt` unchanged, and the new word to appear as the 16th entry.
- **Graceful end:** With 5 entries queued, assert `test_ending` while `dct_valid`=1 on that edge. Expect `level`=6. Further `dct_valid` is ignored with `overflow_cnt` unchanged. Drain with `out_ready`=1; expect `done`=1 one edge after the last pop.
- **Abort:** With 7 entries queued, assert `test_ending` and `test_has_ended` together. Expect `done`=1, `level`=0 and `out_valid`=0 after one edge.
- **Reset mid-drain:** Assert `reset` asynchronously during DRAIN. Expect all outputs at their reset values immediately, and a subsequent capture to work normally.
